cla_pipelined_subtractor: RTL and testbench
===========================================

# cla_pipelined_subtractor

Two-stage pipelined parallel-prefix subtractor computing D = A − B − Bin with a borrow-out, wrapped in a valid/ready handshake. It uses the same bitwise-PG → group-PG → final-sum structure as the combinational lookahead adder, run in the inverse direction: A + ~B + ~Bin, with the carry reinterpreted as borrow. Registers sit after the bitwise-PG stage and after the sum stage. It is the subtract path the datapath uses wherever a lookahead adder sits on the add path.

## Interface
- WIDTH, 16: operand and difference width; bits are indexed [WIDTH:1].
- VALENCY, 2: prefix-cell valency in the group-PG network; legal values are 2 or 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled only on the rising edge of clk.
- A  input  [WIDTH:1]  minuend, unsigned.
- B  input  [WIDTH:1]  subtrahend, unsigned.
- Bin  input  1  borrow-in.
- in_valid  input  1  A, B and Bin are valid.
- in_ready  output  1  block can accept an operand this cycle.
- D  output  [WIDTH:1]  difference.
- Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
- out_valid  output  1  D and Bout are valid.
- out_ready  input  1  downstream accepts the result this cycle.

## Operation
- Arithmetic is modulo 2^WIDTH: {~Bout, D} = A + ~B + ~Bin over WIDTH+1 bits.
  - Internal carry-in is ~Bin. Bit 0 of the PG vector carries G0 = ~Bin, P0 = 0.
  - Bout = ~(carry out of bit WIDTH).
- Stage 1 (S1) registers on acceptance:
  - G[WIDTH:1] = A & ~B
  - P[WIDTH:1] = A ^ ~B
  - G0
  - s1_valid
- Stage 2 (S2) computes from the S1 registers:
  - group-PG prefix (VALENCY-radix tree) producing Gi[WIDTH:0]
  - sum D[i] = P[i] ^ Gi[i−1]
  - Bout = ~Gi[WIDTH]
  - It registers D, Bout and s2_valid.
- Flow control uses per-stage load enables; there is no separate FSM. Each stage is EMPTY or FULL through its valid bit.
  - en2 = ~s2_valid | out_ready
  - en1 = ~s1_valid | en2
  - in_ready = en1 & rst_n
- When en1 is high, S1 loads in_valid and the PG terms. When en2 is high, S2 loads s1_valid and the stage-2 results.
- Data registers load only when their stage's valid input is 1. Bubbles keep the previous D/Bout, and D/Bout are don't-care while out_valid = 0.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Both may occur in the same cycle. The pipeline then shifts, with no loss and no duplication.
- Handshake rules:
  - Once out_valid = 1 and out_ready = 0, D, Bout and out_valid hold stable until the output transfer.
  - in_valid is not required to stay asserted without in_ready; the block samples only on a transfer.
- Order is strictly FIFO.

## Timing
- Reset (rst_n = 0 at an edge) sets s1_valid, s2_valid, out_valid, D and Bout to 0.
- in_ready is 0 while rst_n = 0 and is 1 in the first cycle after reset deasserts.
- Reset mid-operation discards both in-flight operands; no output transfer of them ever occurs.
- Latency: an operand accepted at edge k presents out_valid = 1 after edge k+1, so it is visible in cycle k+1 and transferable at edge k+2.
- Throughput is one result per cycle while out_ready = 1.
- Full stall: with S1 and S2 both FULL and out_ready = 0, in_ready = 0 in that same cycle. out_ready → in_ready is a combinational path.
- After out_ready rises with both stages FULL, that cycle has an output transfer and accepts a new input: in_ready = 1.
- Wrap-around: A = 0, B = 2^WIDTH − 1, Bin = 1 gives D = 0 and Bout = 1.

## Configuration
- CLA_SUB_SATURATE_EN defined: when Bout = 1, D is forced to 0 before the S2 register. Bout is still reported as 1, and latency is unchanged.
- CLA_SUB_SATURATE_EN undefined: D is the modulo-2^WIDTH difference described above.

## Test plan
- Reset then basic subtract (WIDTH = 16): A = 0x1234, B = 0x0234, Bin = 0 → D = 0x1000, Bout = 0, with out_valid exactly 2 edges after acceptance.
- Underflow: A = 0x0000, B = 0x0001, Bin = 0 → D = 0xFFFF, Bout = 1. With CLA_SUB_SATURATE_EN: D = 0x0000, Bout = 1.
- Borrow-in: A = 0x8000, B = 0x7FFF, Bin = 1 → D = 0x0000, Bout = 0. A = 0, B = 0xFFFF, Bin = 1 → D = 0x0000, Bout = 1.
- Streaming: 100 back-to-back random operands with out_ready = 1 → 100 results in order, one per cycle, each matching the reference model, with in_ready constantly 1.
- Backpressure: hold out_ready = 0 for 5 cycles while feeding 3 operands → only 2 accepted, in_ready = 0 once both stages are full, D/Bout stable. Release → results drain in order and the 3rd operand is then accepted.
- Reset mid-stream: assert rst_n = 0 for one edge with both stages FULL → out_valid = 0, D = 0, Bout = 0 next cycle, and no stale result appears afterward.

Source files
------------

// File: rtl/cla_pipelined_subtractor_if.sv
// Operand/result handshake bundle for cla_pipelined_subtractor.
// The master drives operands and out_ready; the slave (the subtractor) drives results and in_ready.
interface cla_pipelined_subtractor_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH:1] A;
    logic [WIDTH:1] B;
    logic           Bin;
    logic           in_valid;
    logic           in_ready;
    logic [WIDTH:1] D;
    logic           Bout;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output A, B, Bin, in_valid, out_ready,
        input  in_ready, D, Bout, out_valid
    );

    modport slave (
        input  A, B, Bin, in_valid, out_ready,
        output in_ready, D, Bout, out_valid
    );
endinterface

// File: rtl/cla_pipelined_subtractor.sv
// Two-stage parallel-prefix subtractor, D = A - B - Bin, computed as A + ~B + ~Bin with borrow = ~carry.
// Optional CLA_SUB_SATURATE_EN clamps D to zero whenever a borrow-out occurs.
module cla_pipelined_subtractor #(
    parameter int WIDTH   = 16,
    parameter int VALENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cla_pipelined_subtractor_if.slave   bus
);

    function automatic int calc_levels(input int n, input int v);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        for (int k = 0; k < 32; k++) begin
            if (span < n) begin
                span = span * v;
                lv   = lv + 1;
            end else begin
                span = span;
            end
        end
        return lv;
    endfunction

    // Prefix depth needed for the tree to span bit 0 (the carry-in) up to bit WIDTH.
    localparam int LEVELS = calc_levels(WIDTH + 1, VALENCY);

    logic           s1_valid_q, s1_valid_d;
    logic [WIDTH:1] s1_g_q, s1_g_d;
    logic [WIDTH:1] s1_p_q, s1_p_d;
    logic           s1_g0_q, s1_g0_d;
    logic           s2_valid_q, s2_valid_d;
    logic [WIDTH:1] d_q, d_d;
    logic           bout_q, bout_d;
    logic           en1_s, en2_s;

    // A stage may load when it is empty or when the stage after it is moving.
    assign en2_s        = ~s2_valid_q | bus.out_ready;
    assign en1_s        = ~s1_valid_q | en2_s;
    assign bus.in_ready = en1_s & rst_n;

    // Stage-1 next state: bitwise generate/propagate of A + ~B, carry-in ~Bin.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_g0_d    = s1_g0_q;
        if (en1_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_g_d  = bus.A & ~bus.B;
                s1_p_d  = bus.A ^ ~bus.B;
                s1_g0_d = ~bus.Bin;
            end else begin
                s1_g_d  = s1_g_q;
                s1_p_d  = s1_p_q;
                s1_g0_d = s1_g0_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Group-PG prefix tree; level 0 holds the bitwise terms with bit 0 = (G0 = ~Bin, P0 = 0).
    wire [LEVELS:0][WIDTH:0] g_lvl_s;
    wire [LEVELS:0][WIDTH:0] p_lvl_s;
    logic                    unused_p_s;

    assign g_lvl_s[0] = {s1_g_q, s1_g0_q};
    assign p_lvl_s[0] = {s1_p_q, 1'b0};
    assign unused_p_s = ^p_lvl_s[LEVELS];

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int SPAN = VALENCY ** l;
        for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
            localparam int J1 = i - SPAN;
            localparam int J2 = i - 2 * SPAN;
            localparam int J3 = i - 3 * SPAN;
            logic g1_s, p1_s;

            if (J1 >= 0) begin : g_m1
                assign g1_s = g_lvl_s[l][i] | (p_lvl_s[l][i] & g_lvl_s[l][J1]);
                assign p1_s = p_lvl_s[l][i] & p_lvl_s[l][J1];
            end else begin : g_t1
                assign g1_s = g_lvl_s[l][i];
                assign p1_s = p_lvl_s[l][i];
            end

            if (VALENCY == 4) begin : g_v4
                logic g2_s, p2_s, g3_s, p3_s;
                if (J2 >= 0) begin : g_m2
                    assign g2_s = g1_s | (p1_s & g_lvl_s[l][J2]);
                    assign p2_s = p1_s & p_lvl_s[l][J2];
                end else begin : g_t2
                    assign g2_s = g1_s;
                    assign p2_s = p1_s;
                end
                if (J3 >= 0) begin : g_m3
                    assign g3_s = g2_s | (p2_s & g_lvl_s[l][J3]);
                    assign p3_s = p2_s & p_lvl_s[l][J3];
                end else begin : g_t3
                    assign g3_s = g2_s;
                    assign p3_s = p2_s;
                end
                assign g_lvl_s[l+1][i] = g3_s;
                assign p_lvl_s[l+1][i] = p3_s;
            end else begin : g_v2
                assign g_lvl_s[l+1][i] = g1_s;
                assign p_lvl_s[l+1][i] = p1_s;
            end
        end
    end

    logic [WIDTH:0] gi_s;
    logic [WIDTH:1] d_calc_s;
    logic           bout_calc_s;

    assign gi_s        = g_lvl_s[LEVELS];
    assign bout_calc_s = ~gi_s[WIDTH];

    // Sum bits from the prefix carries, optionally clamped on borrow.
    always_comb begin
        d_calc_s = s1_p_q ^ gi_s[WIDTH-1:0];
`ifdef CLA_SUB_SATURATE_EN
        if (bout_calc_s) begin
            d_calc_s = {WIDTH{1'b0}};
        end else begin
            d_calc_s = s1_p_q ^ gi_s[WIDTH-1:0];
        end
`endif
    end

    // Stage-2 next state: bubbles leave the previous D/Bout in place.
    always_comb begin
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bout_d     = bout_q;
        if (en2_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d    = d_calc_s;
                bout_d = bout_calc_s;
            end else begin
                d_d    = d_q;
                bout_d = bout_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= {WIDTH{1'b0}};
            s1_p_q     <= {WIDTH{1'b0}};
            s1_g0_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= {WIDTH{1'b0}};
            bout_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_g0_q    <= s1_g0_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
        end
    end

    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.out_valid = s2_valid_q;

endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// Self-checking bench for cla_pipelined_subtractor: directed cases, streaming, backpressure, mid-stream reset.
// Honours CLA_SUB_SATURATE_EN in its reference model.
module tb_cla_pipelined_subtractor;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    cla_pipelined_subtractor_if #(.WIDTH(W)) bus ();

    cla_pipelined_subtractor #(.WIDTH(W), .VALENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W:0]   exp_q[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_out    = 0;
    logic         in_fired;
    logic         ir_seen;
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    logic         ops_c[3];
    int           idx;
    int           out_before;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] diff;
        diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
`ifdef CLA_SUB_SATURATE_EN
        if (diff[W]) diff[W-1:0] = '0;
`endif
        return diff;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: settle inputs, score transfers, cross the edge, land 1 time unit after it.
    task automatic step();
        logic [W:0] e;
        #2;
        in_fired = 1'b0;
        ir_seen  = bus.in_ready;
        if (bus.out_valid && bus.out_ready && rst_n) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("queue_nonempty_at_output", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_D", 32'(bus.D), 32'(e[W-1:0]));
                chk("sb_Bout", 32'(bus.Bout), 32'(e[W]));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_sub(bus.A, bus.B, bus.Bin));
            in_fired = 1'b1;
        end
        @(posedge clk);
        if (!rst_n) exp_q.delete();
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        bus.in_valid = 1'b1;
    endtask

    task automatic run_directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bin, input logic [W-1:0] d_exp, input logic bo_exp);
        bus.out_ready = 1'b1;
        drive(a, b, bin);
        step();
        chk({tag, "_accept"}, 32'(in_fired), 32'd1);
        bus.in_valid = 1'b0;
        chk({tag, "_valid_k"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({tag, "_valid_k1"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_D"}, 32'(bus.D), 32'(d_exp));
        chk({tag, "_Bout"}, 32'(bus.Bout), 32'(bo_exp));
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_D", 32'(bus.D), 32'd0);
        chk("rst_Bout", 32'(bus.Bout), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_directed("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
`ifdef CLA_SUB_SATURATE_EN
        run_directed("underflow", 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_directed("alt_bits", 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1);
`else
        run_directed("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run_directed("alt_bits", 16'h5555, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1);
`endif
        run_directed("bin_exact", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
        run_directed("wrap", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        run_directed("max_minus_0", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0);

        // Streaming: back-to-back random operands with the sink always ready.
        bus.out_ready = 1'b1;
        out_before    = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)));
            step();
            chk("stream_in_ready", 32'(ir_seen), 32'd1);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("stream_count", 32'(n_out - out_before), 32'd100);
        chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: sink stalled for 5 cycles while offering 3 operands.
        for (int i = 0; i < 3; i++) begin
            ops_a[i] = W'($urandom);
            ops_b[i] = W'($urandom);
            ops_c[i] = 1'($urandom_range(1, 0));
        end
        bus.out_ready = 1'b0;
        idx           = 0;
        for (int c = 0; c < 5; c++) begin
            drive(ops_a[idx], ops_b[idx], ops_c[idx]);
            step();
            if (in_fired) idx++;
            if (c >= 2) begin
                chk("stall_in_ready", 32'(ir_seen), 32'd0);
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_D", 32'(bus.D), 32'(ref_sub(ops_a[0], ops_b[0], ops_c[0]) & 17'h0FFFF));
                chk("stall_Bout", 32'(bus.Bout), 32'(ref_sub(ops_a[0], ops_b[0], ops_c[0]) >> W));
            end
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        bus.out_ready = 1'b1;
        step();
        chk("release_in_ready", 32'(ir_seen), 32'd1);
        chk("release_accept", 32'(in_fired), 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full: the in-flight operands must never emerge.
        bus.out_ready = 1'b0;
        drive(16'h4321, 16'h0321, 1'b0);
        step();
        drive(16'h0010, 16'h0020, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_D", 32'(bus.D), 32'd0);
        chk("midrst_Bout", 32'(bus.Bout), 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_directed("after_rst", 16'h00FF, 16'h000F, 1'b1, 16'h00EF, 1'b0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
